sram_dump_tx: RTL and testbench



---
 rtl/sram_dump_tx_if.sv | 25 ++
 rtl/sram_dump_tx.sv | 174 +++++++++++++++++
 tb/tb_sram_dump_tx.sv | 466 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_dump_tx_if.sv
// Control handshake and SRAM read port shared by the dump engine and its host.
interface sram_dump_tx_if #(
    parameter int ADDR_WIDTH = 10
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  busy;
    logic                  done;
    logic                  sram_rd_en;
    logic [ADDR_WIDTH-1:0] sram_addr;
    logic [31:0]           sram_data_out;

    // Host side: issues dump requests and returns SRAM read data.
    modport master (
        output start, start_addr, word_count, sram_data_out,
        input  busy, done, sram_rd_en, sram_addr
    );

    // Dump engine side.
    modport slave (
        input  start, start_addr, word_count, sram_data_out,
        output busy, done, sram_rd_en, sram_addr
    );
endinterface

// File: rtl/sram_dump_tx.sv
// sram_dump_tx: streams a window of the firmware SRAM out over a UART TX pin
// as an 8N1 byte stream: a header byte, then each word LSB byte first.
module sram_dump_tx #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         ADDR_WIDTH   = 10,
    parameter logic [7:0] HEADER_BYTE  = 8'h53
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sram_dump_tx_if.slave bus,
    output logic          o_tx_pin
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   COUNT_ONE = (ADDR_WIDTH + 1)'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_HDR    = 3'd1;
    localparam logic [2:0] ST_RD_REQ = 3'd2;
    localparam logic [2:0] ST_RD_LAT = 3'd3;
    localparam logic [2:0] ST_SEND   = 3'd4;
    localparam logic [2:0] ST_FIN    = 3'd5;

    logic [2:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_curAddr;
    logic [ADDR_WIDTH-1:0] r_sramAddr;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [31:0]           r_wordBuf;
    logic [1:0]            r_byteIdx;

    logic                  r_txBit;
    logic                  r_txActive;
    logic [CNT_W-1:0]      r_clkCnt;
    logic [3:0]            r_bitIdx;
    logic [7:0]            r_txShift;

    logic [2:0]            w_stateNext;
    logic                  w_load;
    logic [7:0]            w_loadByte;
    logic                  w_frameEnd;

    // The last cycle of a stop bit; the FSM reacts on this edge so the line
    // never sits idle longer than the SRAM read needs.
    assign w_frameEnd = r_txActive && (r_clkCnt == CNT_LAST) && (r_bitIdx == 4'd9);

    assign o_tx_pin       = r_txBit;
    assign bus.busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign bus.done       = (r_state == ST_FIN);
    assign bus.sram_rd_en = (r_state == ST_RD_REQ);
    assign bus.sram_addr  = r_sramAddr;

    // Next-state decode plus the request to load a new byte into the serializer.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        w_loadByte  = 8'h00;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_stateNext = ST_HDR;
                    w_load      = 1'b1;
                    w_loadByte  = HEADER_BYTE;
                end
            end
            ST_HDR: begin
                if (w_frameEnd) begin
                    w_stateNext = (r_remaining == '0) ? ST_FIN : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                w_stateNext = ST_RD_LAT;
            end
            ST_RD_LAT: begin
                w_stateNext = ST_SEND;
                w_load      = 1'b1;
                w_loadByte  = bus.sram_data_out[7:0];
            end
            ST_SEND: begin
                if (w_frameEnd && (r_byteIdx == 2'd3)) begin
                    w_stateNext = (r_remaining == COUNT_ONE) ? ST_FIN : ST_RD_REQ;
                end else if (!r_txActive) begin
                    w_load     = 1'b1;
                    w_loadByte = r_wordBuf[7:0];
                end
            end
            ST_FIN: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers: state, address/count bookkeeping and word buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_curAddr   <= '0;
            r_sramAddr  <= '0;
            r_remaining <= '0;
            r_wordBuf   <= '0;
            r_byteIdx   <= '0;
        end else begin
            r_state <= w_stateNext;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_curAddr   <= bus.start_addr;
                        r_remaining <= bus.word_count;
                    end
                end
                ST_HDR: begin
                    if (w_frameEnd && (r_remaining != '0)) begin
                        r_sramAddr <= r_curAddr;
                    end
                end
                ST_RD_LAT: begin
                    r_wordBuf <= {8'h00, bus.sram_data_out[31:8]};
                    r_byteIdx <= 2'd0;
                end
                ST_SEND: begin
                    if (w_frameEnd && (r_byteIdx == 2'd3)) begin
                        r_remaining <= r_remaining - COUNT_ONE;
                        r_curAddr   <= r_curAddr + ADDR_ONE;
                        if (r_remaining != COUNT_ONE) begin
                            r_sramAddr <= r_curAddr + ADDR_ONE;
                        end
                    end else if (w_load) begin
                        r_wordBuf <= {8'h00, r_wordBuf[31:8]};
                        r_byteIdx <= r_byteIdx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // 8N1 serializer: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_txBit    <= 1'b1;
            r_txActive <= 1'b0;
            r_clkCnt   <= '0;
            r_bitIdx   <= '0;
            r_txShift  <= '0;
        end else if (w_load) begin
            r_txShift  <= w_loadByte;
            r_txBit    <= 1'b0;
            r_txActive <= 1'b1;
            r_clkCnt   <= '0;
            r_bitIdx   <= '0;
        end else if (r_txActive) begin
            if (r_clkCnt == CNT_LAST) begin
                r_clkCnt <= '0;
                if (r_bitIdx == 4'd9) begin
                    r_txActive <= 1'b0;
                    r_bitIdx   <= '0;
                    r_txBit    <= 1'b1;
                end else begin
                    r_bitIdx <= r_bitIdx + 4'd1;
                    r_txBit  <= (r_bitIdx == 4'd8) ? 1'b1 : r_txShift[r_bitIdx[2:0]];
                end
            end else begin
                r_clkCnt <= r_clkCnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_sram_dump_tx.sv
// tb_sram_dump_tx: directed bench for the SRAM-to-UART dump engine.
module tb_sram_dump_tx;

    localparam int CPB = 4;
    localparam int AW  = 10;

    logic clk      = 1'b0;
    logic rst      = 1'b1;
    logic tx;
    logic monClear = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] mem [0:1023];
    logic [9:0]  hdrFrame = 10'b1010100110;

    logic [7:0] rxBytes [$];
    int         gaps    [$];
    int         rdAddrs [$];
    int         doneCount   = 0;
    int         busyAtDone  = 0;
    int         glitchCount = 0;
    int         frameErr    = 0;
    int         cyc         = 0;

    sram_dump_tx_if #(.ADDR_WIDTH(AW)) bus ();

    sram_dump_tx #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW),
        .HEADER_BYTE  (8'h53)
    ) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .bus      (bus.slave),
        .o_tx_pin (tx)
    );

    always #5 clk = ~clk;

    // SRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (bus.sram_rd_en) bus.sram_data_out <= mem[bus.sram_addr];
    end

    // UART receiver and bus observer, sampling on the falling edge.
    initial begin : monitor
        bit         mActive;
        bit         haveLast;
        int         mPos;
        int         k;
        int         lastEnd;
        logic [7:0] mByte;
        logic       mBit;
        mActive  = 0;
        haveLast = 0;
        mPos     = 0;
        lastEnd  = 0;
        mByte    = 8'h00;
        mBit     = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst || monClear) begin
                mActive  = 0;
                haveLast = 0;
                if (monClear) begin
                    rxBytes.delete();
                    gaps.delete();
                    rdAddrs.delete();
                    doneCount   = 0;
                    busyAtDone  = 0;
                    glitchCount = 0;
                    frameErr    = 0;
                end
            end else begin
                if (bus.sram_rd_en === 1'b1) rdAddrs.push_back(int'(bus.sram_addr));
                if (bus.done === 1'b1) begin
                    doneCount++;
                    if (bus.busy !== 1'b0) busyAtDone++;
                end
                if (!mActive && tx === 1'b0) begin
                    mActive = 1;
                    mPos    = 0;
                    mByte   = 8'h00;
                    if (haveLast) gaps.push_back(cyc - lastEnd);
                end
                if (mActive) begin
                    if (mPos % CPB == 0) begin
                        mBit = tx;
                        k    = mPos / CPB;
                        if (k >= 1 && k <= 8) mByte[k-1] = tx;
                        if (k == 9 && tx !== 1'b1) frameErr++;
                    end else if (tx !== mBit) begin
                        glitchCount++;
                    end
                    mPos++;
                    if (mPos == 10 * CPB) begin
                        rxBytes.push_back(mByte);
                        mActive  = 0;
                        haveLast = 1;
                        lastEnd  = cyc + 1;
                    end
                end
            end
        end
    end

    task automatic clearMon();
        monClear = 1'b1;
        @(posedge clk); #1;
        monClear = 1'b0;
    endtask

    task automatic startDump(input logic [AW-1:0] a, input logic [AW:0] n);
        bus.start_addr = a;
        bus.word_count = n;
        bus.start      = 1'b1;
        @(posedge clk); #1;
        bus.start      = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic runDump(input logic [AW-1:0] a, input logic [AW:0] n, output bit ok);
        clearMon();
        startDump(a, n);
        waitDone((1 + 4 * int'(n)) * 45 + 50, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nChecks++;
        if (tx !== 1'b1) begin nFails++; $display("[TB] FAIL reset_tx: got %b expected 1", tx); end
        nChecks++;
        if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
        nChecks++;
        if (bus.done !== 1'b0) begin nFails++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
        nChecks++;
        if (bus.sram_rd_en !== 1'b0) begin nFails++; $display("[TB] FAIL reset_rd_en: got %b expected 0", bus.sram_rd_en); end
        nChecks++;
        if (bus.sram_addr !== 10'd0) begin nFails++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.sram_addr); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_header_only();
        clearMon();
        startDump(10'd0, 11'd0);
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            nChecks++;
            if (tx !== hdrFrame[i / CPB]) begin
                nFails++;
                $display("[TB] FAIL hdr_bit cycle %0d: got %b expected %b", i, tx, hdrFrame[i / CPB]);
            end
            if (i == 0) begin
                nChecks++;
                if (bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL hdr_busy_start: got %b expected 1", bus.busy); end
            end
        end
        @(negedge clk);
        nChecks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL hdr_done_pulse: got done=%b busy=%b expected done=1 busy=0", bus.done, bus.busy);
        end
        @(negedge clk);
        nChecks++;
        if (bus.done !== 1'b0) begin nFails++; $display("[TB] FAIL hdr_done_width: got %b expected 0", bus.done); end
        @(posedge clk); #1;
        nChecks++;
        if (rdAddrs.size() != 0) begin nFails++; $display("[TB] FAIL hdr_no_read: got %0d reads expected 0", rdAddrs.size()); end
        nChecks++;
        if (rxBytes.size() != 1 || rxBytes[0] !== 8'h53) begin
            nFails++;
            $display("[TB] FAIL hdr_byte: got %0d bytes expected one 0x53", rxBytes.size());
        end
    endtask

    task automatic test_single_word();
        bit         ok;
        int         badGaps;
        logic [7:0] exp [0:4];
        exp      = '{8'h53, 8'h11, 8'h22, 8'h33, 8'h44};
        mem[5]   = 32'h44332211;
        runDump(10'd5, 11'd1, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL single_timeout: got no done expected done"); end
        nChecks++;
        if (rxBytes.size() != 5) begin
            nFails++;
            $display("[TB] FAIL single_len: got %0d bytes expected 5", rxBytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nChecks++;
                if (rxBytes[i] !== exp[i]) begin
                    nFails++;
                    $display("[TB] FAIL single_byte[%0d]: got %h expected %h", i, rxBytes[i], exp[i]);
                end
            end
        end
        nChecks++;
        if (rdAddrs.size() != 1 || rdAddrs[0] != 5) begin
            nFails++;
            $display("[TB] FAIL single_reads: got %0d reads expected one read of addr 5", rdAddrs.size());
        end
        nChecks++;
        if (doneCount != 1 || busyAtDone != 0) begin
            nFails++;
            $display("[TB] FAIL single_done: got %0d pulses busyAtDone=%0d expected 1 and 0", doneCount, busyAtDone);
        end
        badGaps = 0;
        foreach (gaps[i]) if (gaps[i] < 1 || gaps[i] > 3) badGaps++;
        nChecks++;
        if (gaps.size() != 4 || badGaps != 0) begin
            nFails++;
            $display("[TB] FAIL single_gaps: got %0d gaps (%0d out of 1..3) expected 4 in range", gaps.size(), badGaps);
        end
        nChecks++;
        if (glitchCount != 0 || frameErr != 0) begin
            nFails++;
            $display("[TB] FAIL single_framing: got glitches=%0d stopErr=%0d expected 0", glitchCount, frameErr);
        end
    endtask

    task automatic test_wrap();
        bit         ok;
        logic [7:0] exp [0:8];
        exp       = '{8'h53, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        mem[1023] = 32'hA1B2C3D4;
        mem[0]    = 32'h0F0E0D0C;
        runDump(10'd1023, 11'd2, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL wrap_timeout: got no done expected done"); end
        nChecks++;
        if (rxBytes.size() != 9) begin
            nFails++;
            $display("[TB] FAIL wrap_len: got %0d bytes expected 9", rxBytes.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                nChecks++;
                if (rxBytes[i] !== exp[i]) begin
                    nFails++;
                    $display("[TB] FAIL wrap_byte[%0d]: got %h expected %h", i, rxBytes[i], exp[i]);
                end
            end
        end
        nChecks++;
        if (rdAddrs.size() != 2 || rdAddrs[0] != 1023 || rdAddrs[1] != 0) begin
            nFails++;
            $display("[TB] FAIL wrap_reads: got %0d reads expected 1023 then 0", rdAddrs.size());
        end
    endtask

    task automatic test_ignored_start();
        bit         ok;
        logic [7:0] exp [0:4];
        exp    = '{8'h53, 8'h11, 8'h22, 8'h33, 8'h44};
        mem[5] = 32'h44332211;
        clearMon();
        startDump(10'd5, 11'd1);
        repeat (10) @(posedge clk);
        #1;
        startDump(10'd0, 11'd3);
        repeat (128) @(posedge clk);
        #1;
        startDump(10'd1023, 11'd2);
        waitDone(400, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL ignore_timeout: got no done expected done"); end
        repeat (100) @(posedge clk);
        #1;
        nChecks++;
        if (rxBytes.size() != 5) begin
            nFails++;
            $display("[TB] FAIL ignore_len: got %0d bytes expected 5", rxBytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nChecks++;
                if (rxBytes[i] !== exp[i]) begin
                    nFails++;
                    $display("[TB] FAIL ignore_byte[%0d]: got %h expected %h", i, rxBytes[i], exp[i]);
                end
            end
        end
        nChecks++;
        if (rdAddrs.size() != 1 || rdAddrs[0] != 5) begin
            nFails++;
            $display("[TB] FAIL ignore_reads: got %0d reads expected one read of addr 5", rdAddrs.size());
        end
        nChecks++;
        if (doneCount != 1 || bus.busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL ignore_done: got %0d pulses busy=%b expected 1 pulse busy=0", doneCount, bus.busy);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit         ok;
        int         lineLow;
        logic [7:0] exp [0:4];
        exp    = '{8'h53, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        mem[5] = 32'h44332211;
        mem[0] = 32'h0F0E0D0C;
        clearMon();
        startDump(10'd5, 11'd1);
        repeat (90) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (tx !== 1'b1 || bus.busy !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL midrst_line: got tx=%b busy=%b expected tx=1 busy=0", tx, bus.busy);
        end
        nChecks++;
        if (bus.sram_rd_en !== 1'b0 || bus.done !== 1'b0 || bus.sram_addr !== 10'd0) begin
            nFails++;
            $display("[TB] FAIL midrst_outputs: got rd_en=%b done=%b addr=%0d expected 0 0 0",
                     bus.sram_rd_en, bus.done, bus.sram_addr);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        lineLow = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bus.busy !== 1'b0) lineLow++;
        end
        nChecks++;
        if (lineLow != 0) begin nFails++; $display("[TB] FAIL midrst_no_resume: got %0d active cycles expected 0", lineLow); end
        @(posedge clk); #1;
        runDump(10'd0, 11'd1, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL midrst_timeout: got no done expected done"); end
        nChecks++;
        if (rxBytes.size() != 5) begin
            nFails++;
            $display("[TB] FAIL midrst_len: got %0d bytes expected 5", rxBytes.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                nChecks++;
                if (rxBytes[i] !== exp[i]) begin
                    nFails++;
                    $display("[TB] FAIL midrst_byte[%0d]: got %h expected %h", i, rxBytes[i], exp[i]);
                end
            end
        end
        nChecks++;
        if (rdAddrs.size() != 1 || rdAddrs[0] != 0) begin
            nFails++;
            $display("[TB] FAIL midrst_reads: got %0d reads expected one read of addr 0", rdAddrs.size());
        end
    endtask

    task automatic test_wrap_long();
        bit ok;
        int badBytes;
        int badReads;
        int badGaps;
        int a;
        for (int i = 0; i < 1024; i++) mem[i] = 32'(i);
        runDump(10'd1016, 11'd16, ok);
        nChecks++;
        if (!ok) begin nFails++; $display("[TB] FAIL long_timeout: got no done expected done"); end
        nChecks++;
        if (rxBytes.size() != 65) begin
            nFails++;
            $display("[TB] FAIL long_len: got %0d bytes expected 65", rxBytes.size());
        end else begin
            badBytes = (rxBytes[0] !== 8'h53) ? 1 : 0;
            for (int w = 0; w < 16; w++) begin
                a = (1016 + w) % 1024;
                if (rxBytes[1 + 4*w] !== 8'(a & 255)) badBytes++;
                if (rxBytes[2 + 4*w] !== 8'(a >> 8))  badBytes++;
                if (rxBytes[3 + 4*w] !== 8'h00)       badBytes++;
                if (rxBytes[4 + 4*w] !== 8'h00)       badBytes++;
            end
            nChecks++;
            if (badBytes != 0) begin nFails++; $display("[TB] FAIL long_bytes: got %0d wrong bytes expected 0", badBytes); end
        end
        badReads = (rdAddrs.size() != 16) ? 1 : 0;
        foreach (rdAddrs[i]) if (rdAddrs[i] != (1016 + i) % 1024) badReads++;
        nChecks++;
        if (badReads != 0) begin
            nFails++;
            $display("[TB] FAIL long_reads: got %0d reads (%0d errors) expected 16 in order", rdAddrs.size(), badReads);
        end
        badGaps = 0;
        foreach (gaps[i]) if (gaps[i] < 1 || gaps[i] > 3) badGaps++;
        nChecks++;
        if (gaps.size() != 64 || badGaps != 0) begin
            nFails++;
            $display("[TB] FAIL long_gaps: got %0d gaps (%0d out of 1..3) expected 64 in range", gaps.size(), badGaps);
        end
        nChecks++;
        if (doneCount != 1 || glitchCount != 0 || frameErr != 0) begin
            nFails++;
            $display("[TB] FAIL long_done_framing: got done=%0d glitches=%0d stopErr=%0d expected 1 0 0",
                     doneCount, glitchCount, frameErr);
        end
    endtask

    task automatic test_count_max();
        clearMon();
        startDump(10'd0, 11'd1024);
        repeat (400) @(posedge clk);
        #1;
        nChecks++;
        if (bus.busy !== 1'b1 || doneCount != 0) begin
            nFails++;
            $display("[TB] FAIL max_running: got busy=%b done=%0d expected busy=1 done=0", bus.busy, doneCount);
        end
        nChecks++;
        if (rdAddrs.size() < 2 || rdAddrs[0] != 0 || rdAddrs[1] != 1) begin
            nFails++;
            $display("[TB] FAIL max_reads: got %0d reads expected addr 0 then 1", rdAddrs.size());
        end
        nChecks++;
        if (rxBytes.size() < 6 || rxBytes[0] !== 8'h53 || rxBytes[1] !== 8'h00 || rxBytes[5] !== 8'h01) begin
            nFails++;
            $display("[TB] FAIL max_bytes: got %0d bytes expected 53 00 .. 01 prefix", rxBytes.size());
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        nChecks++;
        if (bus.busy !== 1'b0 || tx !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL max_abort: got busy=%b tx=%b expected busy=0 tx=1", bus.busy, tx);
        end
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.word_count = '0;
        test_reset();
        test_header_only();
        test_single_word();
        test_wrap();
        test_ignored_start();
        test_reset_mid_frame();
        test_wrap_long();
        test_count_max();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
